ddr_line_mover: RTL and testbench

- Cache-miss sequencer between the L2/cache miss logic and the DDR controller's word-addressed block port.
- Takes one request: an optional dirty-victim writeback plus an optional line fill, each a 256-bit line.
- Splits each line into two 128-bit half beats, selected by ram_addr[2], and drives them to the DDR controller.
- Paces each beat on ram_rdy, assembles the fill line, and reports completion with a single done pulse.

---
 rtl/ddr_line_mover_if.sv | 33 +++
 rtl/ddr_line_mover.sv | 120 ++++++++++++
 tb/tb_ddr_line_mover.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_line_mover_if.sv
// Bundle of the request/completion and DDR block-port signals of ddr_line_mover.
// master: cache-miss side plus DDR controller model (drives req_*, ram_rdy, block_in).
// slave:  the line mover itself (drives req_ready, done, err, fill_data, ram_*, data_to_ram).
interface ddr_line_mover_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_wb;
  logic [29:0]  req_wb_addr;
  logic [255:0] req_wb_data;
  logic         req_fill;
  logic [29:0]  req_fill_addr;
  logic         done;
  logic         err;
  logic [255:0] fill_data;
  logic         ram_en;
  logic         ram_write;
  logic [29:0]  ram_addr;
  logic [255:0] data_to_ram;
  logic         ram_rdy;
  logic [255:0] block_in;

  modport master (
    output req_valid, req_wb, req_wb_addr, req_wb_data, req_fill, req_fill_addr,
    output ram_rdy, block_in,
    input  req_ready, done, err, fill_data, ram_en, ram_write, ram_addr, data_to_ram
  );

  modport slave (
    input  req_valid, req_wb, req_wb_addr, req_wb_data, req_fill, req_fill_addr,
    input  ram_rdy, block_in,
    output req_ready, done, err, fill_data, ram_en, ram_write, ram_addr, data_to_ram
  );
endinterface

// File: rtl/ddr_line_mover.sv
// Cache-miss sequencer: optional victim writeback then optional line fill, each
// moved as two 128-bit half beats over the DDR controller's word-addressed block port.
// Ports: clk, rst (sync, active-low), bus (slave side of ddr_line_mover_if).
module ddr_line_mover #(
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 12
) (
  input logic            clk,
  input logic            rst,
  ddr_line_mover_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WB_LO, WB_HI, FILL_LO, FILL_HI, DONE_ST
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            wait_ph;     // 0 = ISSUE cycle of a beat, 1 = WAIT phase
  logic [TO_W-1:0] to_cnt;
  logic            fill_f;
  logic [29:0]     wb_line;
  logic [29:0]     fill_line;
  logic [29:0]     wb_src;
  logic [29:0]     fill_src;
  logic [29:0]     addr_nxt;
  logic            in_beat;
  logic            beat_ok;
  logic            tmo;

  always_comb begin
    in_beat = state inside {WB_LO, WB_HI, FILL_LO, FILL_HI};
    // ram_rdy is stale during ISSUE, so only the WAIT phase can complete a beat
    beat_ok = in_beat & wait_ph & bus.ram_rdy;
    tmo     = in_beat & wait_ph & ~bus.ram_rdy & (to_cnt == TO_W'(TIMEOUT - 1));
    // The first beat is issued on the accept edge, before the line registers load
    wb_src   = (state == IDLE) ? {bus.req_wb_addr[29:3], 3'b000}   : wb_line;
    fill_src = (state == IDLE) ? {bus.req_fill_addr[29:3], 3'b000} : fill_line;

    state_nxt = state;
    case (state)
      IDLE:
        if (bus.req_valid)
          state_nxt = bus.req_wb ? WB_LO : (bus.req_fill ? FILL_LO : DONE_ST);
      WB_LO:
        if (beat_ok)  state_nxt = WB_HI;
        else if (tmo) state_nxt = DONE_ST;
      WB_HI:
        if (beat_ok)  state_nxt = fill_f ? FILL_LO : DONE_ST;
        else if (tmo) state_nxt = DONE_ST;
      FILL_LO:
        if (beat_ok)  state_nxt = FILL_HI;
        else if (tmo) state_nxt = DONE_ST;
      FILL_HI:
        if (beat_ok || tmo) state_nxt = DONE_ST;
      DONE_ST:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase

    case (state_nxt)
      WB_LO:   addr_nxt = wb_src;
      WB_HI:   addr_nxt = wb_src | 30'd4;
      FILL_LO: addr_nxt = fill_src;
      FILL_HI: addr_nxt = fill_src | 30'd4;
      default: addr_nxt = bus.ram_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      wait_ph         <= 1'b0;
      to_cnt          <= '0;
      fill_f          <= 1'b0;
      wb_line         <= '0;
      fill_line       <= '0;
      bus.req_ready   <= 1'b1;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.fill_data   <= '0;
      bus.ram_en      <= 1'b0;
      bus.ram_write   <= 1'b0;
      bus.ram_addr    <= '0;
      bus.data_to_ram <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && bus.req_valid) begin
        wb_line         <= wb_src;
        fill_line       <= fill_src;
        fill_f          <= bus.req_fill;
        bus.data_to_ram <= bus.req_wb_data;
      end

      // Every state change lands in a fresh ISSUE (or leaves the beat states)
      if (state_nxt != state) begin
        wait_ph <= 1'b0;
        to_cnt  <= '0;
      end else if (in_beat) begin
        if (!wait_ph) wait_ph <= 1'b1;
        else          to_cnt  <= to_cnt + 1'b1;
      end

      if (tmo) bus.err <= 1'b1;

      if (state == FILL_LO && beat_ok) bus.fill_data[127:0]   <= bus.block_in[127:0];
      if (state == FILL_HI && beat_ok) bus.fill_data[255:128] <= bus.block_in[255:128];

      // Outputs follow the next state so they line up with it cycle for cycle
      bus.ram_en    <= state_nxt inside {WB_LO, WB_HI, FILL_LO, FILL_HI};
      bus.ram_write <= state_nxt inside {WB_LO, WB_HI};
      bus.ram_addr  <= addr_nxt;
      bus.done      <= (state_nxt == DONE_ST);
      bus.req_ready <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_ddr_line_mover.sv
// Bench for ddr_line_mover: directed requests against a DDR controller model,
// expected beats and completions queued at issue time and popped by monitors.
// Ports: none (top level).
module tb_ddr_line_mover;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ddr_line_mover_if bus();
  ddr_line_mover #(.TIMEOUT(16), .TO_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [29:0] a; logic w; logic [255:0] d; } bexp_t;
  typedef struct { int lat; logic cf; logic [255:0] fe; logic ee; int t; } dexp_t;

  bexp_t beat_q[$];
  dexp_t done_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_on = 0;

  localparam logic [255:0] WD = 256'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_11223344;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // DDR controller model: ready drops while addr/op is new, returns after dly WAIT cycles
  int          dly = 0;
  logic        force_rdy = 1'b0;
  logic        p_en = 1'b0;
  logic        p_wr = 1'b0;
  logic [29:0] p_addr = '0;
  int          w_cnt = 0;
  logic        chg;

  assign chg = (bus.ram_en !== p_en) || (bus.ram_addr !== p_addr) || (bus.ram_write !== p_wr);
  assign bus.ram_rdy  = force_rdy | (bus.ram_en & ~chg & (w_cnt >= dly));
  assign bus.block_in = {8{bus.ram_addr, 2'b10}};

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    p_en   <= bus.ram_en;
    p_addr <= bus.ram_addr;
    p_wr   <= bus.ram_write;
    w_cnt  <= chg ? 0 : w_cnt + 1;
  end

  // Monitors
  logic        m_en = 1'b0;
  logic        m_wr = 1'b0;
  logic [29:0] m_addr = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.ram_en === 1'b1 && (m_en !== 1'b1 || bus.ram_addr !== m_addr || bus.ram_write !== m_wr)) begin
        if (beat_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_beat: got addr %h write %b want no beat", bus.ram_addr, bus.ram_write);
        end else begin
          bexp_t b;
          b = beat_q.pop_front();
          chk("beat_addr", 256'(bus.ram_addr), 256'(b.a));
          chk("beat_write", 256'(bus.ram_write), 256'(b.w));
          if (b.w) chk("beat_data", bus.data_to_ram, b.d);
        end
      end
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d want 0", cyc);
        end else begin
          dexp_t e;
          e = done_q.pop_front();
          chk("done_latency", 256'(cyc - e.t + 1), 256'(e.lat));
          if (e.cf) chk("fill_data", bus.fill_data, e.fe);
          chk("done_err", 256'(bus.err), 256'(e.ee));
          chk("done_ram_en", 256'(bus.ram_en), 256'(0));
        end
      end
    end
    m_en   <= bus.ram_en;
    m_addr <= bus.ram_addr;
    m_wr   <= bus.ram_write;
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_vec++; n_bad++;
      $display("FAIL ready_timeout: got req_ready=%b want 1 within 300 cycles", bus.req_ready);
    end
  endtask

  task automatic send(input logic wb, input logic fill, input logic [29:0] wa, input logic [29:0] fa,
                      input int lat, input logic cf, input logic [255:0] fe, input logic ee,
                      input bit push_done, input bit hold);
    logic [29:0] wl, fl;
    wait_ready();
    wl = {wa[29:3], 3'b000};
    fl = {fa[29:3], 3'b000};
    if (wb) begin
      beat_q.push_back('{wl, 1'b1, WD});
      beat_q.push_back('{wl | 30'd4, 1'b1, WD});
    end
    if (fill) begin
      beat_q.push_back('{fl, 1'b0, 256'd0});
      beat_q.push_back('{fl | 30'd4, 1'b0, 256'd0});
    end
    bus.req_valid = 1'b1; bus.req_wb = wb; bus.req_fill = fill;
    bus.req_wb_addr = wa; bus.req_fill_addr = fa; bus.req_wb_data = WD;
    @(posedge clk);
    #1;
    if (push_done) done_q.push_back('{lat, cf, fe, ee, cyc});
    @(negedge clk);
    if (hold) begin
      chk("busy_req_ready", 256'(bus.req_ready), 256'(0));
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((done_q.size() != 0 || bus.req_ready !== 1'b1) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending completions want 0", done_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.req_valid = 1'b0; bus.req_wb = 1'b0; bus.req_fill = 1'b0;
    bus.req_wb_addr = '0; bus.req_fill_addr = '0; bus.req_wb_data = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 256'(bus.req_ready), 256'(1));
    chk("rst_ram_en", 256'(bus.ram_en), 256'(0));
    chk("rst_done", 256'(bus.done), 256'(0));
    chk("rst_err", 256'(bus.err), 256'(0));
    chk("rst_fill_data", bus.fill_data, 256'd0);
    chk("rst_ram_addr", 256'(bus.ram_addr), 256'(0));
    rst = 1'b1;
    mon_on = 1;

    // Writeback + fill with a slow controller: ISSUE + 4 WAIT cycles per beat
    dly = 3;
    send(1, 1, 30'h40, 30'h80, 21, 1, {{4{30'h84, 2'b10}}, {4{30'h80, 2'b10}}}, 0, 1, 0);
    wait_drain();

    // Fill only at the top of the address space, immediate ready
    dly = 0;
    send(0, 1, 30'h0, 30'h3fff_fffb, 5, 1,
         {{4{30'h3fff_fffc, 2'b10}}, {4{30'h3fff_fff8, 2'b10}}}, 0, 1, 0);
    wait_drain();

    // No-op request, req_valid held through DONE
    send(0, 0, 30'h0, 30'h0, 1, 0, 256'd0, 0, 1, 1);
    wait_drain();

    // Ready high even during ISSUE, same line for wb and fill
    force_rdy = 1'b1;
    send(1, 1, 30'h200, 30'h200, 9, 1, {{4{30'h204, 2'b10}}, {4{30'h200, 2'b10}}}, 0, 1, 0);
    wait_drain();
    force_rdy = 1'b0;

    // Timeout: controller never ready
    dly = 100000;
    send(0, 1, 30'h0, 30'h100, 18, 0, 256'd0, 1, 1, 0);
    beat_q.delete(1);  // the HI beat is abandoned
    wait_drain();
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", 256'(bus.err), 256'(1));
    chk("tmo_ram_en", 256'(bus.ram_en), 256'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("tmo_err_cleared", 256'(bus.err), 256'(0));

    // Reset during the WB_HI WAIT
    dly = 3;
    send(1, 0, 30'h40, 30'h0, 0, 0, 256'd0, 0, 0, 0);
    k = 0;
    while (!(bus.ram_en === 1'b1 && bus.ram_addr === 30'h44) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_vec++; n_bad++;
      $display("FAIL wb_hi_seen: got addr %h want 00000044 within 100 cycles", bus.ram_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ram_en", 256'(bus.ram_en), 256'(0));
    chk("midrst_req_ready", 256'(bus.req_ready), 256'(1));
    chk("midrst_done", 256'(bus.done), 256'(0));
    rst = 1'b1;

    // A normal request after the abandoned one
    dly = 0;
    send(1, 1, 30'h1c0, 30'h1c8, 9, 1, {{4{30'h1cc, 2'b10}}, {4{30'h1c8, 2'b10}}}, 0, 1, 0);
    wait_drain();
    repeat (3) @(negedge clk);

    chk("beats_left", 256'(beat_q.size()), 256'(0));
    chk("dones_left", 256'(done_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
